// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: prefetching instruction fetch with in-order memory port.
// Optional misaligned-pc detection is enabled by defining IFU_MISALIGN_CHECK_EN.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH      = 4,
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter logic [31:0] NOP_INSTR       = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    input  logic        instr_req,
    input  logic        trap,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic        fetch_err,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        FLUSH,
        HALT
    } state_t;

    state_t        state;
    logic [31:0]   fetch_addr;
    logic [OW-1:0] outstanding;
    logic [OW-1:0] out_nxt;
    logic [CW-1:0] count;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [31:0]   addr_q [FIFO_DEPTH];
    logic [31:0]   data_q [FIFO_DEPTH];

    logic [31:0] pc_word;
    logic [31:0] pc_cmp;
    logic        misalign;
    logic        fifo_empty;
    logic [31:0] head_addr;
    logic [31:0] head_data;
    logic [31:0] inflight_addr;
    logic [31:0] exp_addr;
    logic        redirect;
    logic        flush;
    logic        accept;
    logic        resp;
    logic        push;
    logic        pop;

    assign pc_word = {pc[31:2], 2'b00};

`ifdef IFU_MISALIGN_CHECK_EN
    assign pc_cmp   = pc;
    assign misalign = instr_req && (pc[1:0] != 2'b00);
`else
    logic unused_pc_bits;
    assign unused_pc_bits = ^pc[1:0];
    assign pc_cmp   = pc_word;
    assign misalign = 1'b0;
`endif

    assign fetch_err = misalign;
    assign mem_addr  = fetch_addr;

    // Head compare, redirect detection and memory request gating.
    always_comb begin
        fifo_empty    = (count == '0);
        head_addr     = addr_q[rd_ptr];
        head_data     = data_q[rd_ptr];
        // Requests are contiguous, so the oldest in-flight word sits
        // `outstanding` words behind the next fetch address.
        inflight_addr = fetch_addr - (32'(outstanding) << 2);
        exp_addr      = fifo_empty ? inflight_addr : head_addr;

        instr_valid = (state == FETCH) && !trap && !fifo_empty
                      && (head_addr == pc_cmp) && !misalign;
        instr       = instr_valid ? head_data : NOP_INSTR;

        redirect = (state == FETCH) && !trap && instr_req
                   && !misalign && (pc_cmp != exp_addr);
        flush    = redirect || ((state != IDLE) && trap);

        mem_req = (state == FETCH) && !trap && !redirect
                  && (32'(outstanding) < MAX_OUTSTANDING)
                  && (32'(count) + 32'(outstanding) < FIFO_DEPTH);

        accept = mem_req && mem_gnt;
        resp   = mem_rvalid && (outstanding != '0);
        push   = resp && (state == FETCH) && !trap && !redirect;
        pop    = instr_valid && instr_req;

        unique case ({accept, resp})
            2'b10:   out_nxt = outstanding + 1'b1;
            2'b01:   out_nxt = outstanding - 1'b1;
            default: out_nxt = outstanding;
        endcase
    end

    // Fetch FSM, fetch pointer, in-flight counter and FIFO bookkeeping.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            fetch_addr  <= RESET_PC;
            outstanding <= '0;
            count       <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
        end else begin
            outstanding <= out_nxt;

            if (flush) begin
                count  <= '0;
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
                unique case ({push, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end

            if (accept) fetch_addr <= fetch_addr + 32'd4;

            unique case (state)
                IDLE: state <= FETCH;
                FETCH: begin
                    if (trap) begin
                        state <= HALT;
                    end else if (redirect) begin
                        fetch_addr <= pc_word;
                        state      <= (out_nxt != '0) ? FLUSH : FETCH;
                    end
                end
                FLUSH: begin
                    if (trap)                state <= HALT;
                    else if (out_nxt == '0)  state <= FETCH;
                end
                HALT: begin
                    if (!trap) begin
                        fetch_addr <= pc_word;
                        state      <= (out_nxt != '0) ? FLUSH : FETCH;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Prefetch storage: address tag and data for each returned word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else if (push) begin
            addr_q[wr_ptr] <= inflight_addr;
            data_q[wr_ptr] <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: scoreboard bench for instr_fetch_unit.
// Define IFU_MISALIGN_CHECK_EN here too when the RTL is built with it.
module tb_instr_fetch_unit;

    localparam logic [31:0] K   = 32'hA5A5_0000;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] pc = '0;
    logic        instr_req = 1'b0;
    logic        trap = 1'b0;
    logic [31:0] instr;
    logic        instr_valid;
    logic        fetch_err;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;

    exp_t        exp_q[$];
    logic [31:0] exp_addr_q[$];
    logic [31:0] mem_q[$];
    exp_t        mon_e;

    int   n_pass = 0;
    int   n_total = 0;
    int   n_acc = 0;
    int   n_cyc;
    logic auto_pc = 1'b0;
    logic rsp_en = 1'b0;

    always #5 clk = ~clk;

    instr_fetch_unit dut (
        .clk        (clk),
        .reset      (reset),
        .pc         (pc),
        .instr_req  (instr_req),
        .trap       (trap),
        .instr      (instr),
        .instr_valid(instr_valid),
        .fetch_err  (fetch_err),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic expect_instr(input logic [31:0] a, input logic [31:0] d);
        exp_q.push_back({a, d});
    endtask

    // One clock: sample core/memory handshakes, then drive the next inputs.
    task automatic cyc();
        logic took;
        @(negedge clk);
        took = instr_valid && instr_req;
        if (mem_req && mem_gnt) begin
            mem_q.push_back(mem_addr);
            n_acc++;
        end
        @(posedge clk);
        #1;
        if (auto_pc && took) pc = pc + 32'd4;
        if (rsp_en && mem_q.size() != 0) begin
            mem_rvalid = 1'b1;
            mem_rdata  = mem_q.pop_front() ^ K;
        end else begin
            mem_rvalid = 1'b0;
            mem_rdata  = '0;
        end
    endtask

    task automatic do_reset();
        reset      = 1'b0;
        instr_req  = 1'b0;
        trap       = 1'b0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        rsp_en     = 1'b0;
        auto_pc    = 1'b0;
        mem_q.delete();
        exp_q.delete();
        exp_addr_q.delete();
        #1;
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_instr", instr, NOP);
        check("rst_instr_valid", 32'(instr_valid), 32'd0);
        check("rst_fetch_err", 32'(fetch_err), 32'd0);
        cyc();
        cyc();
        reset = 1'b1;
        n_acc = 0;
    endtask

    task automatic drain(input string name, input int maxc, output int n);
        n = 0;
        while ((exp_q.size() != 0 || exp_addr_q.size() != 0) && n < maxc) begin
            cyc();
            n++;
        end
        check(name, 32'(exp_q.size() + exp_addr_q.size()), 32'd0);
    endtask

    // Scoreboard monitor: consumed instructions and accepted addresses.
    always @(negedge clk) begin
        if (reset) begin
            if (instr_valid && instr_req) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_instr", 32'(instr_valid), 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("instr", instr, mon_e.d);
                    check("instr_pc", pc, mon_e.a);
                end
            end
            if (mem_req && mem_gnt && exp_addr_q.size() != 0)
                check("mem_addr", mem_addr, exp_addr_q.pop_front());
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Streaming: one word per cycle from address 0.
        do_reset();
        pc = 32'h0; instr_req = 1'b1; mem_gnt = 1'b1;
        rsp_en = 1'b1; auto_pc = 1'b1;
        for (int i = 0; i < 8; i++) begin
            expect_instr(32'(i * 4), 32'(i * 4) ^ K);
            exp_addr_q.push_back(32'(i * 4));
        end
        drain("stream_drain", 40, n_cyc);
        check("stream_cycles", 32'(n_cyc), 32'd11);

        // Outstanding limit, then FIFO fill to depth.
        do_reset();
        pc = 32'h0; mem_gnt = 1'b1;
        exp_addr_q.push_back(32'h0);
        exp_addr_q.push_back(32'h4);
        repeat (6) cyc();
        check("max_out_req", 32'(mem_req), 32'd0);
        check("max_out_acc", 32'(n_acc), 32'd2);
        rsp_en = 1'b1;
        exp_addr_q.push_back(32'h8);
        exp_addr_q.push_back(32'hC);
        repeat (12) cyc();
        check("full_req", 32'(mem_req), 32'd0);
        check("full_acc", 32'(n_acc), 32'd4);
        check("full_valid", 32'(instr_valid), 32'd1);
        check("full_instr", instr, 32'hA5A5_0000);
        check("full_addr_q", 32'(exp_addr_q.size()), 32'd0);

        // Redirect with two words buffered and two in flight.
        do_reset();
        pc = 32'h10; instr_req = 1'b1;
        cyc();
        cyc();
        instr_req = 1'b0; mem_gnt = 1'b1;
        exp_addr_q.push_back(32'h10);
        exp_addr_q.push_back(32'h14);
        exp_addr_q.push_back(32'h18);
        exp_addr_q.push_back(32'h1C);
        repeat (4) cyc();
        mem_gnt = 1'b0; rsp_en = 1'b1;
        repeat (4) cyc();
        mem_gnt = 1'b1; rsp_en = 1'b0;
        repeat (4) cyc();
        check("pre_jump_valid", 32'(instr_valid), 32'd1);
        check("pre_jump_instr", instr, 32'hA5A5_0010);
        check("pre_jump_acc", 32'(n_acc), 32'd4);
        exp_addr_q.push_back(32'h100);
        expect_instr(32'h100, 32'hA5A5_0100);
        pc = 32'h100; instr_req = 1'b1; rsp_en = 1'b1; auto_pc = 1'b1;
        cyc();
        check("flush_valid", 32'(instr_valid), 32'd0);
        check("flush_instr", instr, NOP);
        check("flush_req0", 32'(mem_req), 32'd0);
        cyc();
        check("flush_req1", 32'(mem_req), 32'd0);
        cyc();
        drain("jump_drain", 20, n_cyc);

        // Trap for three cycles while streaming, resume at 0x40.
        do_reset();
        pc = 32'h0; instr_req = 1'b1; mem_gnt = 1'b1;
        rsp_en = 1'b1; auto_pc = 1'b1;
        expect_instr(32'h0, 32'hA5A5_0000);
        expect_instr(32'h4, 32'hA5A5_0004);
        expect_instr(32'h8, 32'hA5A5_0008);
        expect_instr(32'hC, 32'hA5A5_000C);
        drain("pre_trap_drain", 30, n_cyc);
        trap = 1'b1; auto_pc = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("trap_req", 32'(mem_req), 32'd0);
            check("trap_valid", 32'(instr_valid), 32'd0);
            cyc();
        end
        check("trap_instr", instr, NOP);
        pc = 32'h40; trap = 1'b0; auto_pc = 1'b1;
        exp_addr_q.push_back(32'h40);
        exp_addr_q.push_back(32'h44);
        expect_instr(32'h40, 32'hA5A5_0040);
        expect_instr(32'h44, 32'hA5A5_0044);
        drain("resume_drain", 30, n_cyc);

        // Misaligned pc against a full FIFO.
        do_reset();
        pc = 32'h0; mem_gnt = 1'b1; rsp_en = 1'b1;
        repeat (12) cyc();
        check("full_idle_req", 32'(mem_req), 32'd0);
        pc = 32'h102; instr_req = 1'b1;
        #1;
`ifdef IFU_MISALIGN_CHECK_EN
        check("mis102_err", 32'(fetch_err), 32'd1);
`else
        check("mis102_err", 32'(fetch_err), 32'd0);
`endif
        check("mis102_valid", 32'(instr_valid), 32'd0);
        check("mis102_instr", instr, NOP);
        pc = 32'h2;
        #1;
`ifdef IFU_MISALIGN_CHECK_EN
        check("mis2_err", 32'(fetch_err), 32'd1);
        check("mis2_valid", 32'(instr_valid), 32'd0);
        check("mis2_instr", instr, NOP);
`else
        check("mis2_err", 32'(fetch_err), 32'd0);
        check("mis2_valid", 32'(instr_valid), 32'd1);
        check("mis2_instr", instr, 32'hA5A5_0000);
`endif
        instr_req = 1'b0;
        #1;
        check("mis_noreq_err", 32'(fetch_err), 32'd0);
        cyc();

        // Fetch address wraps past the top of the address space.
        do_reset();
        pc = 32'hFFFF_FFF8; instr_req = 1'b1; mem_gnt = 1'b1;
        rsp_en = 1'b1; auto_pc = 1'b1;
        exp_addr_q.push_back(32'hFFFF_FFF8);
        exp_addr_q.push_back(32'hFFFF_FFFC);
        exp_addr_q.push_back(32'h0000_0000);
        expect_instr(32'hFFFF_FFF8, 32'h5A5A_FFF8);
        expect_instr(32'hFFFF_FFFC, 32'h5A5A_FFFC);
        expect_instr(32'h0000_0000, 32'hA5A5_0000);
        drain("wrap_drain", 30, n_cyc);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
